// File: rtl/trace_request_queue_if.sv
// Parser-side and scheduler-side handshake bundle for trace_request_queue.
// The master modport is the environment (parser + scheduler); the slave is the queue.
interface trace_request_queue_if #(
  parameter int TIME_WIDTH     = 64,
  parameter int CPU_CORE_WIDTH = 4,
  parameter int MEM_OPN_WIDTH  = 3,
  parameter int MEM_ADDR_WIDTH = 34
);
  logic                      in_valid;
  logic                      in_ready;
  logic [TIME_WIDTH-1:0]     in_time;
  logic [CPU_CORE_WIDTH-1:0] in_core;
  logic [MEM_OPN_WIDTH-1:0]  in_opn;
  logic [MEM_ADDR_WIDTH-1:0] in_addr;

  logic                      out_valid;
  logic                      out_ready;
  logic [TIME_WIDTH-1:0]     out_time;
  logic [CPU_CORE_WIDTH-1:0] out_core;
  logic [MEM_OPN_WIDTH-1:0]  out_opn;
  logic [15:0]               out_row;
  logic [9:0]                out_col;
  logic [1:0]                out_bank;
  logic [2:0]                out_bg;
  logic                      out_chan;

  modport master (
    output in_valid, in_time, in_core, in_opn, in_addr, out_ready,
    input  in_ready, out_valid, out_time, out_core, out_opn,
           out_row, out_col, out_bank, out_bg, out_chan
  );

  modport slave (
    input  in_valid, in_time, in_core, in_opn, in_addr, out_ready,
    output in_ready, out_valid, out_time, out_core, out_opn,
           out_row, out_col, out_bank, out_bg, out_chan
  );
endinterface

// File: rtl/trace_request_queue.sv
// In-order trace FIFO releasing the head once the CPU-cycle counter reaches its timestamp; push visible at head
// one cycle later, in_ready drops only on registered full. Optional counters under `TRACE_QUEUE_STATS_EN.
module trace_request_queue #(
  parameter int DEPTH          = 16,
  parameter int TIME_WIDTH     = 64,
  parameter int CPU_CORE_WIDTH = 4,
  parameter int MEM_OPN_WIDTH  = 3,
  parameter int MEM_ADDR_WIDTH = 34
) (
  input  logic                     clk,
  input  logic                     rst,
  trace_request_queue_if.slave     q_if,
  output logic [TIME_WIDTH-1:0]    now,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop_err,
  output logic                     order_err
`ifdef TRACE_QUEUE_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]   stat_peak,
  output logic [31:0]              stat_full_cycles,
  output logic [31:0]              stat_issued
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]            DEPTH_C = CW'(DEPTH);
  localparam logic [MEM_OPN_WIDTH-1:0] OPN_MAX = MEM_OPN_WIDTH'(2);

  // addr[1:0] never reaches the scheduler, so only addr[33:2] is stored.
  typedef struct packed {
    logic [TIME_WIDTH-1:0]     ts;
    logic [CPU_CORE_WIDTH-1:0] core;
    logic [MEM_OPN_WIDTH-1:0]  opn;
    logic [MEM_ADDR_WIDTH-3:0] addr;
  } entry_t;

  entry_t                  r_mem [DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic [TIME_WIDTH-1:0]   r_now;
  logic [TIME_WIDTH-1:0]   r_last_time;
  logic                    r_drop_err;
  logic                    r_order_err;

  entry_t                  w_head;
  entry_t                  w_in_entry;
  logic                    w_in_ready;
  logic                    w_out_valid;
  logic                    w_push;
  logic                    w_legal;
  logic                    w_store;
  logic                    w_pop;
  logic                    w_unused_addr_lsb;

  assign w_in_ready  = (r_count < DEPTH_C);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_out_valid = (r_count != '0) && (r_now >= w_head.ts);

  assign w_push  = q_if.in_valid && w_in_ready;
  assign w_legal = (q_if.in_opn <= OPN_MAX);
  assign w_store = w_push && w_legal;
  assign w_pop   = w_out_valid && q_if.out_ready;

  assign w_in_entry.ts   = q_if.in_time;
  assign w_in_entry.core = q_if.in_core;
  assign w_in_entry.opn  = q_if.in_opn;
  assign w_in_entry.addr = q_if.in_addr[MEM_ADDR_WIDTH-1:2];
  assign w_unused_addr_lsb = ^q_if.in_addr[1:0];

  assign q_if.in_ready  = w_in_ready;
  assign q_if.out_valid = w_out_valid;
  assign q_if.out_time  = w_head.ts;
  assign q_if.out_core  = w_head.core;
  assign q_if.out_opn   = w_head.opn;

  // Stored index = physical bit - 2: row addr[33:18], col {addr[17:12], addr[5:2]},
  // bank addr[11:10], bank group addr[9:7], channel addr[6].
  assign q_if.out_row  = w_head.addr[31:16];
  assign q_if.out_col  = {w_head.addr[15:10], w_head.addr[3:0]};
  assign q_if.out_bank = w_head.addr[9:8];
  assign q_if.out_bg   = w_head.addr[7:5];
  assign q_if.out_chan = w_head.addr[4];

  assign now       = r_now;
  assign count     = r_count;
  assign drop_err  = r_drop_err;
  assign order_err = r_order_err;

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_now       <= '0;
      r_last_time <= '0;
      r_drop_err  <= 1'b0;
      r_order_err <= 1'b0;
    end else begin
      r_now <= r_now + TIME_WIDTH'(1);

      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end

      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      // Dropped entries complete the handshake but leave the ordering reference alone.
      if (w_push && !w_legal) begin
        r_drop_err <= 1'b1;
      end
      if (w_store) begin
        if (q_if.in_time < r_last_time) begin
          r_order_err <= 1'b1;
        end
        r_last_time <= q_if.in_time;
      end
    end
  end

`ifdef TRACE_QUEUE_STATS_EN
  logic [CW-1:0] r_stat_peak;
  logic [31:0]   r_stat_full_cycles;
  logic [31:0]   r_stat_issued;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_peak        <= '0;
      r_stat_full_cycles <= '0;
      r_stat_issued      <= '0;
    end else begin
      if (r_count > r_stat_peak) begin
        r_stat_peak <= r_count;
      end
      if (q_if.in_valid && !w_in_ready && (r_stat_full_cycles != '1)) begin
        r_stat_full_cycles <= r_stat_full_cycles + 32'd1;
      end
      if (w_pop && (r_stat_issued != '1)) begin
        r_stat_issued <= r_stat_issued + 32'd1;
      end
    end
  end

  assign stat_peak        = r_stat_peak;
  assign stat_full_cycles = r_stat_full_cycles;
  assign stat_issued      = r_stat_issued;
`endif

endmodule

// File: tb/tb_trace_request_queue.sv
// Bench for trace_request_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_trace_request_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] now;
  logic [4:0]  count;
  logic        drop_err;
  logic        order_err;
`ifdef TRACE_QUEUE_STATS_EN
  logic [4:0]  stat_peak;
  logic [31:0] stat_full_cycles;
  logic [31:0] stat_issued;
`endif

  trace_request_queue_if q_if ();

  trace_request_queue dut (
    .clk       (clk),
    .rst       (rst),
    .q_if      (q_if),
    .now       (now),
    .count     (count),
    .drop_err  (drop_err),
    .order_err (order_err)
`ifdef TRACE_QUEUE_STATS_EN
    ,
    .stat_peak        (stat_peak),
    .stat_full_cycles (stat_full_cycles),
    .stat_issued      (stat_issued)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] ts;
    logic [3:0]  core;
    logic [2:0]  opn;
    logic [33:0] addr;
  } ent_t;

  // Reference model: a plain queue of stored entries plus the cycle counter and sticky flags.
  ent_t        m_q [$];
  logic [63:0] m_now;
  logic [63:0] m_last;
  logic        m_drop;
  logic        m_order;

  int checks = 0;
  int errors = 0;

  function automatic bit exp_valid();
    if (m_q.size() == 0) return 1'b0;
    return m_now >= m_q[0].ts;
  endfunction

  function automatic logic [33:0] rand_addr();
    logic [33:0] a;
    a = {2'($urandom_range(0, 3)), 32'($urandom)};
    return a;
  endfunction

  task automatic drive_in(input logic v, input logic [63:0] t, input logic [3:0] c,
                          input logic [2:0] o, input logic [33:0] a);
    q_if.in_valid = v;
    q_if.in_time  = t;
    q_if.in_core  = c;
    q_if.in_opn   = o;
    q_if.in_addr  = a;
  endtask

  // Advance the model by one clock using the inputs currently driven, then step the DUT.
  task automatic tick();
    bit   push;
    bit   pop;
    ent_t e;
    push = q_if.in_valid && (m_q.size() < 16);
    pop  = q_if.out_ready && exp_valid();
    if (pop) m_q.delete(0);
    if (push) begin
      if (q_if.in_opn > 3'd2) begin
        m_drop = 1'b1;
      end else begin
        if (q_if.in_time < m_last) m_order = 1'b1;
        m_last = q_if.in_time;
        e.ts = q_if.in_time; e.core = q_if.in_core; e.opn = q_if.in_opn; e.addr = q_if.in_addr;
        m_q.push_back(e);
      end
    end
    m_now = m_now + 64'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    q_if.in_valid  = 1'b0;
    q_if.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_q.delete();
    m_now = '0; m_last = '0; m_drop = 1'b0; m_order = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (q_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", q_if.out_valid); end
    checks++; if (q_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", q_if.in_ready); end
    checks++; if (now !== 64'd0) begin errors++; $display("FAIL reset_now: got %0d expected 0", now); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL reset_drop_err: got %b expected 0", drop_err); end
    checks++; if (order_err !== 1'b0) begin errors++; $display("FAIL reset_order_err: got %b expected 0", order_err); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (now !== 64'd3) begin errors++; $display("FAIL now_increment: got %0d expected 3", now); end
  endtask

  task automatic test_single_entry();
    do_reset();
    drive_in(1'b1, 64'd5, 4'd1, 3'd0, 34'h3_FFFF_FFFC);
    tick();
    q_if.in_valid = 1'b0;
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
    for (int i = 0; i < 20 && m_now < 64'd5; i++) begin
      checks++; if (q_if.out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid now=%0d: got %b expected 0", m_now, q_if.out_valid); end
      tick();
    end
    checks++; if (now !== 64'd5) begin errors++; $display("FAIL single_now: got %0d expected 5", now); end
    checks++; if (q_if.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", q_if.out_valid); end
    checks++; if (q_if.out_time !== 64'd5) begin errors++; $display("FAIL single_time: got %0d expected 5", q_if.out_time); end
    checks++; if (q_if.out_core !== 4'd1) begin errors++; $display("FAIL single_core: got %0d expected 1", q_if.out_core); end
    checks++; if (q_if.out_opn !== 3'd0) begin errors++; $display("FAIL single_opn: got %0d expected 0", q_if.out_opn); end
    checks++; if (q_if.out_row !== 16'hFFFF) begin errors++; $display("FAIL single_row: got %h expected ffff", q_if.out_row); end
    checks++; if (q_if.out_col !== 10'h3FF) begin errors++; $display("FAIL single_col: got %h expected 3ff", q_if.out_col); end
    checks++; if (q_if.out_bank !== 2'd3) begin errors++; $display("FAIL single_bank: got %0d expected 3", q_if.out_bank); end
    checks++; if (q_if.out_bg !== 3'd7) begin errors++; $display("FAIL single_bg: got %0d expected 7", q_if.out_bg); end
    checks++; if (q_if.out_chan !== 1'b1) begin errors++; $display("FAIL single_chan: got %b expected 1", q_if.out_chan); end
    q_if.out_ready = 1'b1;
    tick();
    q_if.out_ready = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_pop_count: got %0d expected 0", count); end
    checks++; if (q_if.out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b expected 0", q_if.out_valid); end
  endtask

  task automatic test_full();
    ent_t h;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_in(1'b1, 64'd0, 4'(i), 3'(i % 3), rand_addr());
      tick();
    end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d expected 16", count); end
    checks++; if (q_if.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", q_if.in_ready); end
    drive_in(1'b1, 64'd0, 4'hF, 3'd0, rand_addr());
    tick();
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_17th_count: got %0d expected 16", count); end
    checks++; if (q_if.out_core !== 4'd0) begin errors++; $display("FAIL full_head_core: got %0d expected 0", q_if.out_core); end
    // Full: pop alone happens, the push is refused because in_ready looks at registered count.
    q_if.out_ready = 1'b1;
    tick();
    checks++; if (count !== 5'd15) begin errors++; $display("FAIL full_no_passthru: got %0d expected 15", count); end
    tick();
    checks++; if (count !== 5'd15) begin errors++; $display("FAIL push_pop_same_cycle: got %0d expected 15", count); end
    checks++; if (q_if.out_core !== 4'd2) begin errors++; $display("FAIL push_pop_head_core: got %0d expected 2", q_if.out_core); end
    q_if.in_valid = 1'b0;
    for (int i = 0; i < 40 && m_q.size() != 0; i++) begin
      if (exp_valid()) begin
        h = m_q[0];
        checks++; if (q_if.out_core !== h.core) begin errors++; $display("FAIL drain_core: got %0d expected %0d", q_if.out_core, h.core); end
        checks++; if (q_if.out_row !== h.addr[33:18]) begin errors++; $display("FAIL drain_row: got %h expected %h", q_if.out_row, h.addr[33:18]); end
      end
      tick();
    end
    q_if.out_ready = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", count); end
    checks++; if (q_if.in_ready !== 1'b1) begin errors++; $display("FAIL drain_in_ready: got %b expected 1", q_if.in_ready); end
  endtask

  task automatic test_illegal_opcode();
    do_reset();
    drive_in(1'b1, 64'd0, 4'd2, 3'd5, 34'h123);
    checks++; if (q_if.in_ready !== 1'b1) begin errors++; $display("FAIL illegal_in_ready: got %b expected 1", q_if.in_ready); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL illegal_drop_early: got %b expected 0", drop_err); end
    tick();
    q_if.in_valid = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL illegal_count: got %0d expected 0", count); end
    checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL illegal_drop_err: got %b expected 1", drop_err); end
    checks++; if (order_err !== 1'b0) begin errors++; $display("FAIL illegal_order_err: got %b expected 0", order_err); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (q_if.out_valid !== 1'b0) begin errors++; $display("FAIL illegal_out_valid cyc=%0d: got %b expected 0", i, q_if.out_valid); end
      tick();
    end
  endtask

  task automatic test_order();
    logic [63:0] pop_now [2];
    logic [63:0] pop_t   [2];
    int seen;
    do_reset();
    drive_in(1'b1, 64'd10, 4'd3, 3'd1, rand_addr());
    tick();
    checks++; if (order_err !== 1'b0) begin errors++; $display("FAIL order_first: got %b expected 0", order_err); end
    drive_in(1'b1, 64'd4, 4'd4, 3'd2, rand_addr());
    tick();
    q_if.in_valid = 1'b0;
    checks++; if (order_err !== 1'b1) begin errors++; $display("FAIL order_err: got %b expected 1", order_err); end
    q_if.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && seen < 2; i++) begin
      if (q_if.out_valid === 1'b1) begin
        pop_now[seen] = m_now;
        pop_t[seen]   = q_if.out_time;
        seen++;
      end
      tick();
    end
    q_if.out_ready = 1'b0;
    checks++;
    if (seen !== 2) begin
      errors++; $display("FAIL order_timeout: got %0d pops expected 2", seen);
    end else begin
      checks++; if (pop_t[0] !== 64'd10) begin errors++; $display("FAIL order_pop0_time: got %0d expected 10", pop_t[0]); end
      checks++; if (pop_now[0] !== 64'd10) begin errors++; $display("FAIL order_pop0_now: got %0d expected 10", pop_now[0]); end
      checks++; if (pop_t[1] !== 64'd4) begin errors++; $display("FAIL order_pop1_time: got %0d expected 4", pop_t[1]); end
      checks++; if (pop_now[1] !== 64'd11) begin errors++; $display("FAIL order_pop1_now: got %0d expected 11", pop_now[1]); end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive_in(1'b1, 64'd30, 4'd1, 3'd0, rand_addr()); tick();
    drive_in(1'b1, 64'd20, 4'd2, 3'd1, rand_addr()); tick();
    drive_in(1'b1, 64'd25, 4'd3, 3'd2, rand_addr()); tick();
    drive_in(1'b1, m_last, 4'd4, 3'd6, rand_addr()); tick();
    q_if.in_valid = 1'b0;
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL midrst_pre_count: got %0d expected 3", count); end
    checks++; if ({drop_err, order_err} !== 2'b11) begin errors++; $display("FAIL midrst_pre_flags: got %b expected 11", {drop_err, order_err}); end
    do_reset();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", count); end
    checks++; if (q_if.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", q_if.out_valid); end
    checks++; if (now !== 64'd0) begin errors++; $display("FAIL midrst_now: got %0d expected 0", now); end
    checks++; if (q_if.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", q_if.in_ready); end
    checks++; if ({drop_err, order_err} !== 2'b00) begin errors++; $display("FAIL midrst_flags: got %b expected 00", {drop_err, order_err}); end
  endtask

  task automatic test_random();
    ent_t h;
    bit   e_rdy;
    bit   e_vld;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      q_if.in_valid = ($urandom_range(0, 9) < 6);
      q_if.in_core  = 4'($urandom);
      q_if.in_addr  = rand_addr();
      if ($urandom_range(0, 11) == 0) begin
        q_if.in_opn  = 3'($urandom_range(3, 7));
        q_if.in_time = m_last;
      end else begin
        q_if.in_opn  = 3'($urandom_range(0, 2));
        q_if.in_time = ($urandom_range(0, 7) == 0) ? ((m_now > 64'd8) ? m_now - 64'd8 : 64'd0)
                                                   : m_now + 64'($urandom_range(0, 25));
      end
      q_if.out_ready = 1'($urandom_range(0, 1));
      e_rdy = (m_q.size() < 16);
      e_vld = exp_valid();
      checks++; if (q_if.in_ready !== e_rdy) begin errors++; $display("FAIL rnd_in_ready cyc=%0d: got %b expected %b", cyc, q_if.in_ready, e_rdy); end
      checks++; if (q_if.out_valid !== e_vld) begin errors++; $display("FAIL rnd_out_valid cyc=%0d: got %b expected %b", cyc, q_if.out_valid, e_vld); end
      checks++; if (count !== 5'(m_q.size())) begin errors++; $display("FAIL rnd_count cyc=%0d: got %0d expected %0d", cyc, count, m_q.size()); end
      checks++; if (now !== m_now) begin errors++; $display("FAIL rnd_now cyc=%0d: got %0d expected %0d", cyc, now, m_now); end
      if (e_vld) begin
        h = m_q[0];
        checks++; if (q_if.out_time !== h.ts) begin errors++; $display("FAIL rnd_time cyc=%0d: got %0d expected %0d", cyc, q_if.out_time, h.ts); end
        checks++; if ({q_if.out_core, q_if.out_opn} !== {h.core, h.opn}) begin errors++; $display("FAIL rnd_core_opn cyc=%0d: got %h expected %h", cyc, {q_if.out_core, q_if.out_opn}, {h.core, h.opn}); end
        checks++; if (q_if.out_row !== h.addr[33:18]) begin errors++; $display("FAIL rnd_row cyc=%0d: got %h expected %h", cyc, q_if.out_row, h.addr[33:18]); end
        checks++; if (q_if.out_col !== {h.addr[17:12], h.addr[5:2]}) begin errors++; $display("FAIL rnd_col cyc=%0d: got %h expected %h", cyc, q_if.out_col, {h.addr[17:12], h.addr[5:2]}); end
        checks++; if ({q_if.out_bank, q_if.out_bg, q_if.out_chan} !== {h.addr[11:10], h.addr[9:7], h.addr[6]}) begin errors++; $display("FAIL rnd_bank_bg_chan cyc=%0d: got %h expected %h", cyc, {q_if.out_bank, q_if.out_bg, q_if.out_chan}, {h.addr[11:10], h.addr[9:7], h.addr[6]}); end
      end
      tick();
    end
    q_if.in_valid  = 1'b0;
    q_if.out_ready = 1'b0;
    checks++; if (drop_err !== m_drop) begin errors++; $display("FAIL rnd_drop_err: got %b expected %b", drop_err, m_drop); end
    checks++; if (order_err !== m_order) begin errors++; $display("FAIL rnd_order_err: got %b expected %b", order_err, m_order); end
  endtask

`ifdef TRACE_QUEUE_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 19; i++) begin
      drive_in(1'b1, 64'd0, 4'(i), 3'd0, rand_addr());
      tick();
    end
    q_if.in_valid  = 1'b0;
    q_if.out_ready = 1'b1;
    for (int i = 0; i < 40 && m_q.size() != 0; i++) tick();
    q_if.out_ready = 1'b0;
    tick();
    checks++; if (stat_peak !== 5'd16) begin errors++; $display("FAIL stat_peak: got %0d expected 16", stat_peak); end
    checks++; if (stat_full_cycles !== 32'd3) begin errors++; $display("FAIL stat_full_cycles: got %0d expected 3", stat_full_cycles); end
    checks++; if (stat_issued !== 32'd16) begin errors++; $display("FAIL stat_issued: got %0d expected 16", stat_issued); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_in(1'b0, 64'd0, 4'd0, 3'd0, 34'd0);
    q_if.out_ready = 1'b0;
    test_reset();
    test_single_entry();
    test_full();
    test_illegal_opcode();
    test_order();
    test_mid_reset();
    test_random();
`ifdef TRACE_QUEUE_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
